// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Valid/ready stream carrying fetched instructions toward decode.
interface inst_fetch_ctrl_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (output out_valid, out_inst, out_pc, input out_ready);
  modport slave  (input out_valid, out_inst, out_pc, output out_ready);

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter: byte address, word-aligned, wraps modulo 2^(ADDR_W+2).
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              redir_valid,
  input  logic [31:0]       redir_pc,
  output logic [ADDR_W+1:0] pc
);

  localparam int PC_W = ADDR_W + 2;

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;

  // Redirect bits outside the ROM byte range and the byte offset are dropped.
  logic unused_redir_bits;
  assign unused_redir_bits = ^{redir_pc[31:PC_W], redir_pc[1:0]};

  always_comb begin
    pc_next = pc_reg;
    if (redir_valid) begin
      pc_next = {redir_pc[PC_W-1:2], 2'b00};
    end else if (adv) begin
      pc_next = pc_reg + PC_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC[PC_W-1:0];
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer in front of a combinational ROM.
// Optional macro INST_FETCH_CNT_EN adds a saturating accepted-fetch counter.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    halt_req,
  input  logic                    redir_valid,
  input  logic [31:0]             redir_pc,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [31:0]             rom_inst,
  inst_fetch_ctrl_if.master       dec,
  output logic [1:0]              state_o
`ifdef INST_FETCH_CNT_EN
  ,
  output logic [31:0]             fetch_cnt
`endif
);

  localparam int PC_W = ADDR_W + 2;

  state_t          state_reg;
  logic [PC_W-1:0] pc;
  logic            valid_reg;
  logic [31:0]     inst_reg;
  logic [PC_W-1:0] opc_reg;
  logic            adv;

  assign adv = (state_reg == ST_RUN) && (!valid_reg || dec.out_ready);

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .adv         (adv),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .pc          (pc)
  );

  assign rom_addr = pc[PC_W-1:2];

  // halt_req beats a simultaneous start in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_HALT: if (start && !halt_req) state_reg <= ST_RUN;
        ST_RUN:           if (halt_req)           state_reg <= ST_HALT;
        default:                                  state_reg <= ST_IDLE;
      endcase
    end
  end

  // A redirect flushes the held word even under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      inst_reg  <= '0;
      opc_reg   <= '0;
    end else if (redir_valid) begin
      valid_reg <= 1'b0;
    end else if (adv) begin
      valid_reg <= 1'b1;
      inst_reg  <= rom_inst;
      opc_reg   <= pc;
    end else if (valid_reg && dec.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign dec.out_valid = valid_reg;
  assign dec.out_inst  = inst_reg;
  assign dec.out_pc    = {{(32-PC_W){1'b0}}, opc_reg};
  assign state_o       = state_reg;

`ifdef INST_FETCH_CNT_EN
  logic        handshake;
  logic [31:0] cnt_reg;

  assign handshake = valid_reg && dec.out_ready && !redir_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (handshake && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed and randomized bench for inst_fetch_ctrl with a behavioural fetch model.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic [1:0]  state_o;
`ifdef INST_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  logic [31:0] rom [0:63];
  int checks = 0;
  int failures = 0;

  // Behavioural model: run mode (0 idle, 1 run, 2 halt), next byte address, held word.
  int          m_state;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [7:0]  m_opc;
  longint      m_cnt;

  inst_fetch_ctrl_if dec_if ();

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_addr];

  inst_fetch_ctrl #(
    .ADDR_W   (6),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .dec         (dec_if),
    .state_o     (state_o)
`ifdef INST_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  task automatic model_reset();
    m_state = 0;
    m_pc    = 8'h00;
    m_valid = 1'b0;
    m_inst  = 32'h0;
    m_opc   = 8'h00;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    logic taken;
    logic want;
    taken = m_valid && dec_if.out_ready;
    want  = (m_state == 1) && (!m_valid || dec_if.out_ready);
    if (taken && !redir_valid && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
    if (redir_valid) begin
      m_pc    = redir_pc[7:0] & 8'hFC;
      m_valid = 1'b0;
    end else if (want) begin
      m_inst  = rom[m_pc[7:2]];
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 8'd4;
    end else if (taken) begin
      m_valid = 1'b0;
    end
    if (m_state == 1) begin
      if (halt_req) m_state = 2;
    end else if (start && !halt_req) begin
      m_state = 1;
    end
  endtask

  task automatic cycle();
    if (rst_n && dec_if.out_valid && dec_if.out_ready && !redir_valid)
      $display("xfer pc=%08h inst=%08h", dec_if.out_pc, dec_if.out_inst);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dec_if.out_ready = 1'b0;
    model_reset();
    repeat (2) cycle();
    checks++; if (dec_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", dec_if.out_valid); end
    checks++; if (dec_if.out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%08h exp=0", dec_if.out_inst); end
    checks++; if (dec_if.out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%08h exp=0", dec_if.out_pc); end
    checks++; if (rom_addr !== 6'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [0:2];
    exp_w[0] = 32'h00000000;
    exp_w[1] = 32'h00100443;
    exp_w[2] = 32'h04101025;
    dec_if.out_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL stream_state got=%0d exp=1", state_o); end
    checks++; if (dec_if.out_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid got=%0b exp=0", dec_if.out_valid); end
    cycle();
    checks++; if (dec_if.out_valid !== 1'b1) begin failures++; $display("FAIL stream_first_valid got=%0b exp=1", dec_if.out_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle();
      checks++; if (dec_if.out_pc !== 32'(i * 4)) begin failures++; $display("FAIL stream_pc%0d got=%08h exp=%08h", i, dec_if.out_pc, i * 4); end
      checks++; if (dec_if.out_inst !== exp_w[i]) begin failures++; $display("FAIL stream_inst%0d got=%08h exp=%08h", i, dec_if.out_inst, exp_w[i]); end
    end
  endtask

  task automatic test_backpressure();
    dec_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h8) begin failures++; $display("FAIL bp_hold%0d got valid=%0b pc=%08h exp valid=1 pc=00000008", i, dec_if.out_valid, dec_if.out_pc); end
      checks++; if (dec_if.out_inst !== 32'h04101025) begin failures++; $display("FAIL bp_inst%0d got=%08h exp=04101025", i, dec_if.out_inst); end
      checks++; if (rom_addr !== 6'd3) begin failures++; $display("FAIL bp_rom_addr%0d got=%0d exp=3", i, rom_addr); end
    end
    dec_if.out_ready = 1'b1;
    cycle();
    checks++; if (dec_if.out_pc !== 32'hC || dec_if.out_inst !== 32'h042018e1) begin failures++; $display("FAIL bp_release got pc=%08h inst=%08h exp pc=0000000c inst=042018e1", dec_if.out_pc, dec_if.out_inst); end
  endtask

  task automatic test_redirect();
    dec_if.out_ready = 1'b0;
    redir_valid = 1'b1;
    redir_pc = 32'h17;
    cycle();
    redir_valid = 1'b0;
    checks++; if (dec_if.out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0b exp=0", dec_if.out_valid); end
    checks++; if (rom_addr !== 6'd5) begin failures++; $display("FAIL redir_rom_addr got=%0d exp=5", rom_addr); end
    cycle();
    checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h14) begin failures++; $display("FAIL redir_word got valid=%0b pc=%08h exp valid=1 pc=00000014", dec_if.out_valid, dec_if.out_pc); end
    checks++; if (dec_if.out_inst !== 32'h14002828) begin failures++; $display("FAIL redir_inst got=%08h exp=14002828", dec_if.out_inst); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [0:3];
    exp_pc[0] = 32'hF8; exp_pc[1] = 32'hFC; exp_pc[2] = 32'h00; exp_pc[3] = 32'h04;
    dec_if.out_ready = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 32'hF8;
    cycle();
    redir_valid = 1'b0;
    checks++; if (dec_if.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush got=%0b exp=0", dec_if.out_valid); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== exp_pc[i]) begin failures++; $display("FAIL wrap_pc%0d got valid=%0b pc=%08h exp pc=%08h", i, dec_if.out_valid, dec_if.out_pc, exp_pc[i]); end
    end
  endtask

  task automatic test_halt_resume();
    dec_if.out_ready = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 32'h10;
    cycle();
    redir_valid = 1'b0;
    cycle();
    checks++; if (dec_if.out_pc !== 32'h10) begin failures++; $display("FAIL halt_pre_pc got=%08h exp=00000010", dec_if.out_pc); end
    halt_req = 1'b1;
    dec_if.out_ready = 1'b0;
    cycle();
    halt_req = 1'b0;
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL halt_state got=%0d exp=2", state_o); end
    checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h10) begin failures++; $display("FAIL halt_pending got valid=%0b pc=%08h exp valid=1 pc=00000010", dec_if.out_valid, dec_if.out_pc); end
    dec_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (dec_if.out_valid !== 1'b0 || state_o !== 2'd2) begin failures++; $display("FAIL halt_idle%0d got valid=%0b state=%0d exp valid=0 state=2", i, dec_if.out_valid, state_o); end
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (state_o !== 2'd1 || dec_if.out_valid !== 1'b0) begin failures++; $display("FAIL resume_state got state=%0d valid=%0b exp state=1 valid=0", state_o, dec_if.out_valid); end
    cycle();
    checks++; if (dec_if.out_pc !== 32'h14 || dec_if.out_inst !== 32'h14002828) begin failures++; $display("FAIL resume_word got pc=%08h inst=%08h exp pc=00000014 inst=14002828", dec_if.out_pc, dec_if.out_inst); end
  endtask

`ifdef INST_FETCH_CNT_EN
  task automatic test_fetch_cnt();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++; if (fetch_cnt !== 32'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", fetch_cnt); end
    dec_if.out_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    repeat (5) cycle();
    redir_valid = 1'b1;
    redir_pc = 32'h0;
    cycle();
    redir_valid = 1'b0;
    checks++; if (fetch_cnt !== 32'd5) begin failures++; $display("FAIL cnt_flushed got=%0d exp=5", fetch_cnt); end
    checks++; if (dec_if.out_valid !== 1'b0) begin failures++; $display("FAIL cnt_flush_valid got=%0b exp=0", dec_if.out_valid); end
    cycle();
  endtask
`endif

  task automatic test_async_reset();
    dec_if.out_ready = 1'b1;
    cycle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (dec_if.out_valid !== 1'b0 || dec_if.out_pc !== 32'h0) begin failures++; $display("FAIL arst_out got valid=%0b pc=%08h exp valid=0 pc=0", dec_if.out_valid, dec_if.out_pc); end
    checks++; if (state_o !== 2'd0 || rom_addr !== 6'd0) begin failures++; $display("FAIL arst_state got state=%0d rom_addr=%0d exp 0/0", state_o, rom_addr); end
`ifdef INST_FETCH_CNT_EN
    checks++; if (fetch_cnt !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", fetch_cnt); end
`endif
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      start            = ($urandom % 12) == 0;
      halt_req         = ($urandom % 25) == 0;
      redir_valid      = ($urandom % 14) == 0;
      redir_pc         = $urandom;
      dec_if.out_ready = ($urandom % 4) != 0;
      cycle();
      checks++; if (dec_if.out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, dec_if.out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (dec_if.out_pc !== {24'h0, m_opc} || dec_if.out_inst !== m_inst) begin failures++; $display("FAIL rnd_word n=%0d got pc=%08h inst=%08h exp pc=%08h inst=%08h", n, dec_if.out_pc, dec_if.out_inst, {24'h0, m_opc}, m_inst); end
      end
      checks++; if (rom_addr !== m_pc[7:2]) begin failures++; $display("FAIL rnd_rom_addr n=%0d got=%0d exp=%0d", n, rom_addr, m_pc[7:2]); end
      checks++; if (state_o !== 2'(m_state)) begin failures++; $display("FAIL rnd_state n=%0d got=%0d exp=%0d", n, state_o, m_state); end
`ifdef INST_FETCH_CNT_EN
      checks++; if (fetch_cnt !== m_cnt[31:0]) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, fetch_cnt, m_cnt); end
`endif
    end
    start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h00000000;
    rom[1] = 32'h00100443;
    rom[2] = 32'h04101025;
    rom[3] = 32'h042018e1;
    rom[5] = 32'h14002828;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt_resume();
`ifdef INST_FETCH_CNT_EN
    test_fetch_cnt();
`endif
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
